rename_dispatch_nw: RTL and testbench

- WIDTH-wide rename/dispatch stage, generalising the single-issue rename stage.
- Holds one decoded group and renames all valid slots against the RAT and free list, with intra-group RAW bypass.
- Dispatches the group all-or-nothing to ROB and reservation stations.
- Snoops the CDB while a group is held so source-ready bits are never lost during a stall.

---
 rtl/rename_dispatch_nw_pkg.sv | 40 ++++
 rtl/rename_dispatch_nw_bypass.sv | 75 +++++++
 rtl/rename_dispatch_nw.sv | 225 ++++++++++++++++++++++
 tb/tb_rename_dispatch_nw.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_dispatch_nw_pkg.sv
// Shared types for the multi-wide rename/dispatch stage.
// Default geometry matches the two-wide front end.
package rename_dispatch_nw_pkg;

   localparam int WIDTH_D     = 2;
   localparam int P_REG_NUM_D = 64;
   localparam int PW_D        = $clog2(P_REG_NUM_D);
   localparam int ROB_DEPTH_D = 16;
   localparam int RW_D        = $clog2(ROB_DEPTH_D) + 1;
   localparam int CDB_NUM_D   = 5;
   localparam int NUM_UNITS_D = 5;

   typedef enum logic [2:0] {
      UNIT_ALU = 3'd0,
      UNIT_CMP = 3'd1,
      UNIT_MUL = 3'd2,
      UNIT_DIV = 3'd3,
      UNIT_MEM = 3'd4
   } unit_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rd_en;
      unit_e      unit;
   } rename_slot_t;

   typedef struct packed {
      logic            valid;
      logic [PW_D-1:0] ps1;
      logic [PW_D-1:0] ps2;
      logic [PW_D-1:0] pd;
      logic            rdy1;
      logic            rdy2;
      logic [RW_D-1:0] rob_idx;
   } dispatch_slot_t;

endpackage

// File: rtl/rename_dispatch_nw_bypass.sv
// Combinational group analysis: pd allocation, intra-group RAW
// bypass and per-resource demand counts for the held group.
module rename_bypass_nw
   import rename_dispatch_nw_pkg::*;
#(
   parameter int WIDTH     = 2,
   parameter int PW        = 6,
   parameter int NUM_UNITS = 5,
   parameter int CW        = 2
) (
   input  rename_slot_t [WIDTH-1:0] slot_i,
   input  logic [WIDTH*PW-1:0]      fl_pd_i,
   output logic [WIDTH-1:0]         wr_o,
   output logic [WIDTH*PW-1:0]      pd_o,
   output logic [WIDTH-1:0]         byp1_o,
   output logic [WIDTH-1:0]         byp2_o,
   output logic [WIDTH*PW-1:0]      bps1_o,
   output logic [WIDTH*PW-1:0]      bps2_o,
   output logic [WIDTH*CW-1:0]      rank_o,
   output logic [CW-1:0]            n_o,
   output logic [CW-1:0]            d_o,
   output logic [NUM_UNITS*CW-1:0]  need_o
);

   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] nc;
   logic [CW-1:0] dc;

   always_comb begin
      nc     = '0;
      dc     = '0;
      wr_o   = '0;
      pd_o   = '0;
      rank_o = '0;
      need_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rank_o[i*CW +: CW] = nc;
         if (slot_i[i].valid) nc = nc + ONE;
         wr_o[i] = slot_i[i].valid && slot_i[i].rd_en &&
                   (slot_i[i].rd != 5'd0);
         if (wr_o[i]) begin
            pd_o[i*PW +: PW] = fl_pd_i[int'(dc)*PW +: PW];
            dc = dc + ONE;
         end
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (slot_i[i].valid && slot_i[i].unit == unit_e'(u))
               need_o[u*CW +: CW] = need_o[u*CW +: CW] + ONE;
         end
      end
      n_o = nc;
      d_o = dc;
   end

   // Ascending scan so the youngest earlier writer wins.
   always_comb begin
      byp1_o = '0;
      byp2_o = '0;
      bps1_o = '0;
      bps2_o = '0;
      for (int j = 0; j < WIDTH; j++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (i < j && wr_o[i] && slot_i[i].rd == slot_i[j].rs1) begin
               byp1_o[j]          = 1'b1;
               bps1_o[j*PW +: PW] = pd_o[i*PW +: PW];
            end
            if (i < j && wr_o[i] && slot_i[i].rd == slot_i[j].rs2) begin
               byp2_o[j]          = 1'b1;
               bps2_o[j*PW +: PW] = pd_o[i*PW +: PW];
            end
         end
      end
   end

endmodule

// File: rtl/rename_dispatch_nw.sv
// Multi-wide rename/dispatch stage: holds one group, renames it and
// dispatches it all-or-nothing, snooping the CDB while stalled.
module rename_dispatch_nw
   import rename_dispatch_nw_pkg::*;
#(
   parameter int WIDTH     = WIDTH_D,
   parameter int P_REG_NUM = P_REG_NUM_D,
   parameter int ROB_DEPTH = ROB_DEPTH_D,
   parameter int CDB_NUM   = CDB_NUM_D,
   parameter int NUM_UNITS = NUM_UNITS_D,
   localparam int PW = $clog2(P_REG_NUM),
   localparam int RW = $clog2(ROB_DEPTH) + 1,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        in_valid,
   input  logic [WIDTH*5-1:0]      in_rd,
   input  logic [WIDTH*5-1:0]      in_rs1,
   input  logic [WIDTH*5-1:0]      in_rs2,
   input  logic [WIDTH-1:0]        in_rd_en,
   input  logic [WIDTH*3-1:0]      in_unit,
   output logic                    in_ready,
   input  logic [WIDTH*PW-1:0]     rat_ps1,
   input  logic [WIDTH*PW-1:0]     rat_ps2,
   input  logic [WIDTH-1:0]        rat_rdy1,
   input  logic [WIDTH-1:0]        rat_rdy2,
   output logic [WIDTH-1:0]        rat_we,
   output logic [WIDTH*5-1:0]      rat_rd,
   output logic [WIDTH*PW-1:0]     rat_pd,
   input  logic [WIDTH*PW-1:0]     fl_pd,
   input  logic [PW:0]             fl_count,
   output logic [CW-1:0]           fl_pop,
   input  logic [RW-1:0]           rob_tail,
   input  logic [RW-1:0]           rob_space,
   output logic [CW-1:0]           rob_enq,
   input  logic [NUM_UNITS*CW-1:0] unit_space,
   input  logic [CDB_NUM-1:0]      cdb_we,
   input  logic [CDB_NUM*PW-1:0]   cdb_pd,
   output logic [WIDTH-1:0]        disp_valid,
   output logic [WIDTH*PW-1:0]     disp_ps1,
   output logic [WIDTH*PW-1:0]     disp_ps2,
   output logic [WIDTH*PW-1:0]     disp_pd,
   output logic [WIDTH-1:0]        disp_rdy1,
   output logic [WIDTH-1:0]        disp_rdy2,
   output logic [WIDTH*RW-1:0]     disp_rob_idx,
   output logic [31:0]             stall_cnt
);

   rename_slot_t [WIDTH-1:0] slot_q, slot_d;
   logic                     grp_valid_q, grp_valid_d;
   logic [WIDTH-1:0]         stk1_q, stk1_d;
   logic [WIDTH-1:0]         stk2_q, stk2_d;
   logic [31:0]              stall_q, stall_d;

   logic [WIDTH-1:0]         wr, byp1, byp2;
   logic [WIDTH*PW-1:0]      pd, bps1, bps2;
   logic [WIDTH*CW-1:0]      rank;
   logic [CW-1:0]            n, d;
   logic [NUM_UNITS*CW-1:0]  need;

   logic                     res_ok, fire, accept;
   logic [WIDTH-1:0]         hit1, hit2, rdy1v, rdy2v;
   dispatch_slot_t [WIDTH-1:0] dsp;

   rename_bypass_nw #(
      .WIDTH     (WIDTH),
      .PW        (PW),
      .NUM_UNITS (NUM_UNITS),
      .CW        (CW)
   ) u_bypass (
      .slot_i  (slot_q),
      .fl_pd_i (fl_pd),
      .wr_o    (wr),
      .pd_o    (pd),
      .byp1_o  (byp1),
      .byp2_o  (byp2),
      .bps1_o  (bps1),
      .bps2_o  (bps2),
      .rank_o  (rank),
      .n_o     (n),
      .d_o     (d),
      .need_o  (need)
   );

   always_comb begin
      res_ok = ({{(RW-CW){1'b0}}, n} <= rob_space) &&
               ({{(PW+1-CW){1'b0}}, d} <= fl_count);
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (need[u*CW +: CW] > unit_space[u*CW +: CW]) res_ok = 1'b0;
      end
   end

   assign fire     = grp_valid_q && res_ok && !flush;
   assign in_ready = !grp_valid_q || fire;
   assign accept   = in_ready && (|in_valid) && !flush;

   always_comb begin
      hit1 = '0;
      hit2 = '0;
      for (int j = 0; j < WIDTH; j++) begin
         for (int k = 0; k < CDB_NUM; k++) begin
            if (cdb_we[k] && rat_ps1[j*PW +: PW] != '0 &&
                cdb_pd[k*PW +: PW] == rat_ps1[j*PW +: PW])
               hit1[j] = 1'b1;
            if (cdb_we[k] && rat_ps2[j*PW +: PW] != '0 &&
                cdb_pd[k*PW +: PW] == rat_ps2[j*PW +: PW])
               hit2[j] = 1'b1;
         end
      end
   end

   always_comb begin
      dsp   = '0;
      rdy1v = '0;
      rdy2v = '0;
      for (int j = 0; j < WIDTH; j++) begin
         dsp[j].valid   = slot_q[j].valid;
         dsp[j].pd      = pd[j*PW +: PW];
         dsp[j].rob_idx = rob_tail + {{(RW-CW){1'b0}}, rank[j*CW +: CW]};
         if (slot_q[j].rs1 == 5'd0) begin
            dsp[j].rdy1 = 1'b1;
         end else if (byp1[j]) begin
            dsp[j].ps1 = bps1[j*PW +: PW];
         end else begin
            dsp[j].ps1  = rat_ps1[j*PW +: PW];
            dsp[j].rdy1 = stk1_q[j] | rat_rdy1[j] | hit1[j];
         end
         if (slot_q[j].rs2 == 5'd0) begin
            dsp[j].rdy2 = 1'b1;
         end else if (byp2[j]) begin
            dsp[j].ps2 = bps2[j*PW +: PW];
         end else begin
            dsp[j].ps2  = rat_ps2[j*PW +: PW];
            dsp[j].rdy2 = stk2_q[j] | rat_rdy2[j] | hit2[j];
         end
         rdy1v[j] = dsp[j].rdy1;
         rdy2v[j] = dsp[j].rdy2;
      end
   end

   always_comb begin
      disp_valid   = '0;
      disp_ps1     = '0;
      disp_ps2     = '0;
      disp_pd      = '0;
      disp_rdy1    = '0;
      disp_rdy2    = '0;
      disp_rob_idx = '0;
      rat_we       = '0;
      rat_rd       = '0;
      rat_pd       = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if (fire && slot_q[j].valid) begin
            disp_valid[j]             = 1'b1;
            disp_ps1[j*PW +: PW]      = dsp[j].ps1;
            disp_ps2[j*PW +: PW]      = dsp[j].ps2;
            disp_pd[j*PW +: PW]       = dsp[j].pd;
            disp_rdy1[j]              = dsp[j].rdy1;
            disp_rdy2[j]              = dsp[j].rdy2;
            disp_rob_idx[j*RW +: RW]  = dsp[j].rob_idx;
         end
         if (fire && wr[j]) begin
            rat_we[j]           = 1'b1;
            rat_rd[j*5 +: 5]    = slot_q[j].rd;
            rat_pd[j*PW +: PW]  = pd[j*PW +: PW];
         end
      end
   end

   assign fl_pop    = fire ? d : '0;
   assign rob_enq   = fire ? n : '0;
   assign stall_cnt = stall_q;

   always_comb begin
      grp_valid_d = grp_valid_q;
      slot_d      = slot_q;
      stk1_d      = stk1_q;
      stk2_d      = stk2_q;
      stall_d     = stall_q;
      if (grp_valid_q && !fire && !flush && stall_q != '1)
         stall_d = stall_q + 32'd1;
      if (flush) begin
         grp_valid_d = 1'b0;
         stk1_d      = '0;
         stk2_d      = '0;
      end else if (accept) begin
         grp_valid_d = 1'b1;
         stk1_d      = '0;
         stk2_d      = '0;
         for (int j = 0; j < WIDTH; j++) begin
            slot_d[j].valid = in_valid[j];
            slot_d[j].rd    = in_rd[j*5 +: 5];
            slot_d[j].rs1   = in_rs1[j*5 +: 5];
            slot_d[j].rs2   = in_rs2[j*5 +: 5];
            slot_d[j].rd_en = in_rd_en[j];
            slot_d[j].unit  = unit_e'(in_unit[j*3 +: 3]);
         end
      end else if (fire) begin
         grp_valid_d = 1'b0;
      end else if (grp_valid_q) begin
         // Capture wakeups seen while blocked so they survive the stall.
         stk1_d = rdy1v;
         stk2_d = rdy2v;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grp_valid_q <= 1'b0;
         slot_q      <= '0;
         stk1_q      <= '0;
         stk2_q      <= '0;
         stall_q     <= '0;
      end else begin
         grp_valid_q <= grp_valid_d;
         slot_q      <= slot_d;
         stk1_q      <= stk1_d;
         stk2_q      <= stk2_d;
         stall_q     <= stall_d;
      end
   end

endmodule

// File: tb/tb_rename_dispatch_nw.sv
// Scoreboard bench for rename_dispatch_nw: directed groups push
// expected dispatches, a negedge monitor pops and compares.
module tb_rename_dispatch_nw;

   localparam int W  = 2;
   localparam int PW = 6;
   localparam int RW = 5;
   localparam int CW = 2;
   localparam int NC = 5;
   localparam int NU = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic [W-1:0]    in_valid = '0;
   logic [W*5-1:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [W-1:0]    in_rd_en = '0;
   logic [W*3-1:0]  in_unit = '0;
   logic            in_ready;
   logic [W*PW-1:0] rat_ps1 = '0, rat_ps2 = '0;
   logic [W-1:0]    rat_rdy1 = '0, rat_rdy2 = '0;
   logic [W-1:0]    rat_we;
   logic [W*5-1:0]  rat_rd;
   logic [W*PW-1:0] rat_pd;
   logic [W*PW-1:0] fl_pd;
   logic [PW:0]     fl_count = 7'd64;
   logic [CW-1:0]   fl_pop;
   logic [RW-1:0]   rob_tail = '0;
   logic [RW-1:0]   rob_space = 5'd16;
   logic [CW-1:0]   rob_enq;
   logic [NU*CW-1:0] unit_space = {NU{2'd2}};
   logic [NC-1:0]   cdb_we = '0;
   logic [NC*PW-1:0] cdb_pd = '0;
   logic [W-1:0]    disp_valid;
   logic [W*PW-1:0] disp_ps1, disp_ps2, disp_pd;
   logic [W-1:0]    disp_rdy1, disp_rdy2;
   logic [W*RW-1:0] disp_rob_idx;
   logic [31:0]     stall_cnt;

   rename_dispatch_nw dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_rd_en(in_rd_en), .in_unit(in_unit),
      .in_ready(in_ready),
      .rat_ps1(rat_ps1), .rat_ps2(rat_ps2),
      .rat_rdy1(rat_rdy1), .rat_rdy2(rat_rdy2),
      .rat_we(rat_we), .rat_rd(rat_rd), .rat_pd(rat_pd),
      .fl_pd(fl_pd), .fl_count(fl_count), .fl_pop(fl_pop),
      .rob_tail(rob_tail), .rob_space(rob_space), .rob_enq(rob_enq),
      .unit_space(unit_space), .cdb_we(cdb_we), .cdb_pd(cdb_pd),
      .disp_valid(disp_valid), .disp_ps1(disp_ps1),
      .disp_ps2(disp_ps2), .disp_pd(disp_pd),
      .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
      .disp_rob_idx(disp_rob_idx), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]    valid;
      logic [W*PW-1:0] ps1;
      logic [W*PW-1:0] ps2;
      logic [W*PW-1:0] pd;
      logic [W-1:0]    rdy1;
      logic [W-1:0]    rdy2;
      logic [W*RW-1:0] idx;
      logic [W-1:0]    we;
      logic [W*5-1:0]  rrd;
      logic [CW-1:0]   pop;
      logic [CW-1:0]   enq;
   } exp_t;

   exp_t        q[$];
   exp_t        ex;
   exp_t        me;
   logic [PW-1:0] ratm [32];
   int          tests = 0;
   int          fails = 0;
   bit          mon_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (disp_valid != '0) begin
            if (q.size() == 0) begin
               chk("unexpected_dispatch", 64'(disp_valid), 64'd0);
            end else begin
               me = q.pop_front();
               chk("disp_valid", 64'(disp_valid), 64'(me.valid));
               chk("disp_ps1", 64'(disp_ps1), 64'(me.ps1));
               chk("disp_ps2", 64'(disp_ps2), 64'(me.ps2));
               chk("disp_pd", 64'(disp_pd), 64'(me.pd));
               chk("disp_rdy1", 64'(disp_rdy1), 64'(me.rdy1));
               chk("disp_rdy2", 64'(disp_rdy2), 64'(me.rdy2));
               chk("rob_idx", 64'(disp_rob_idx), 64'(me.idx));
               chk("rat_we", 64'(rat_we), 64'(me.we));
               chk("rat_rd", 64'(rat_rd), 64'(me.rrd));
               chk("rat_pd", 64'(rat_pd), 64'(me.pd));
               chk("fl_pop", 64'(fl_pop), 64'(me.pop));
               chk("rob_enq", 64'(rob_enq), 64'(me.enq));
            end
            for (int i = 0; i < W; i++)
               if (rat_we[i]) ratm[rat_rd[i*5 +: 5]] = rat_pd[i*PW +: PW];
         end else begin
            chk("idle_side", 64'({rat_we, fl_pop, rob_enq}), 64'd0);
         end
      end
   end

   task automatic set_slot(input int s, input bit v, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input bit en, input logic [2:0] u);
      in_valid[s]       = v;
      in_rd[s*5 +: 5]   = rd;
      in_rs1[s*5 +: 5]  = rs1;
      in_rs2[s*5 +: 5]  = rs2;
      in_rd_en[s]       = en;
      in_unit[s*3 +: 3] = u;
   endtask

   task automatic send();
      int k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = '0;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   function automatic logic [W*PW-1:0] p2(input int a1, input int a0);
      return {PW'(a1), PW'(a0)};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) ratm[i] = '0;
      fl_pd = p2(13, 12);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_disp_valid", 64'(disp_valid), 64'd0);
      chk("rst_rat_we", 64'(rat_we), 64'd0);
      chk("rst_fl_pop", 64'(fl_pop), 64'd0);
      chk("rst_rob_enq", 64'(rob_enq), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      mon_on = 1'b1;
      @(posedge clk); #1;

      // intra-group bypass on x5
      set_slot(0, 1, 5'd5, 5'd1, 5'd2, 1, 3'd0);
      set_slot(1, 1, 5'd6, 5'd5, 5'd0, 0, 3'd4);
      rat_ps1 = p2(33, 8); rat_rdy1 = 2'b01;
      rat_ps2 = p2(0, 9);  rat_rdy2 = 2'b00;
      ex = '0;
      ex.valid = 2'b11; ex.ps1 = p2(12, 8); ex.ps2 = p2(0, 9);
      ex.pd = p2(0, 12); ex.rdy1 = 2'b01; ex.rdy2 = 2'b10;
      ex.idx = {5'd1, 5'd0}; ex.we = 2'b01; ex.rrd = {5'd0, 5'd5};
      ex.pop = 2'd1; ex.enq = 2'd2;
      q.push_back(ex);
      send();
      drain();

      // ROB space short by one: held until space arrives
      rob_space = 5'd1;
      rat_ps1 = '0; rat_ps2 = '0; rat_rdy1 = '0; rat_rdy2 = '0;
      set_slot(0, 1, 5'd3, 5'd0, 5'd0, 1, 3'd0);
      set_slot(1, 1, 5'd4, 5'd0, 5'd0, 1, 3'd1);
      send();
      @(negedge clk);
      chk("rob_stall_in_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
      ex = '0;
      ex.valid = 2'b11; ex.pd = p2(13, 12); ex.rdy1 = 2'b11;
      ex.rdy2 = 2'b11; ex.idx = {5'd1, 5'd0}; ex.we = 2'b11;
      ex.rrd = {5'd4, 5'd3}; ex.pop = 2'd2; ex.enq = 2'd2;
      q.push_back(ex);
      rob_space = 5'd2;
      drain();
      rob_space = 5'd16;

      // CDB wakeup while stalled must stick
      rob_space = 5'd0;
      set_slot(0, 1, 5'd0, 5'd0, 5'd10, 0, 3'd2);
      set_slot(1, 0, 5'd0, 5'd0, 5'd0, 0, 3'd0);
      rat_ps2 = p2(0, 20); rat_rdy2 = 2'b00;
      send();
      cdb_we = 5'b01000;
      cdb_pd = '0;
      cdb_pd[3*PW +: PW] = 6'd20;
      @(posedge clk); #1;
      cdb_we = '0; cdb_pd = '0;
      repeat (3) @(posedge clk);
      #1;
      ex = '0;
      ex.valid = 2'b01; ex.ps2 = p2(0, 20); ex.rdy1 = 2'b01;
      ex.rdy2 = 2'b01; ex.enq = 2'd1;
      q.push_back(ex);
      rob_space = 5'd16;
      drain();
      chk("stall_cnt_7", 64'(stall_cnt), 64'd7);
      rat_ps2 = '0;

      // ROB index wraps across the pointer's wrap bit
      rob_tail = 5'd31;
      set_slot(0, 1, 5'd0, 5'd0, 5'd0, 0, 3'd0);
      set_slot(1, 1, 5'd0, 5'd0, 5'd0, 0, 3'd1);
      ex = '0;
      ex.valid = 2'b11; ex.rdy1 = 2'b11; ex.rdy2 = 2'b11;
      ex.idx = {5'd0, 5'd31}; ex.enq = 2'd2;
      q.push_back(ex);
      send();
      drain();
      rob_tail = '0;

      // two writers of x7; younger slot must own the mapping
      fl_pd = p2(4, 3);
      set_slot(0, 1, 5'd7, 5'd0, 5'd0, 1, 3'd0);
      set_slot(1, 1, 5'd7, 5'd0, 5'd0, 1, 3'd0);
      ex = '0;
      ex.valid = 2'b11; ex.pd = p2(4, 3); ex.rdy1 = 2'b11;
      ex.rdy2 = 2'b11; ex.idx = {5'd1, 5'd0}; ex.we = 2'b11;
      ex.rrd = {5'd7, 5'd7}; ex.pop = 2'd2; ex.enq = 2'd2;
      q.push_back(ex);
      send();
      drain();
      chk("rat_x7", 64'(ratm[7]), 64'd4);
      set_slot(0, 1, 5'd0, 5'd7, 5'd0, 0, 3'd1);
      set_slot(1, 0, 5'd0, 5'd0, 5'd0, 0, 3'd0);
      rat_ps1 = p2(0, int'(ratm[7])); rat_rdy1 = 2'b00;
      ex = '0;
      ex.valid = 2'b01; ex.ps1 = p2(0, 4); ex.rdy1 = 2'b00;
      ex.rdy2 = 2'b01; ex.enq = 2'd1;
      q.push_back(ex);
      send();
      drain();
      rat_ps1 = '0;
      fl_pd = p2(13, 12);

      // one ALU slot free, two ALU ops: held one cycle
      unit_space = {2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
      set_slot(0, 1, 5'd8, 5'd0, 5'd0, 1, 3'd0);
      set_slot(1, 1, 5'd9, 5'd0, 5'd0, 1, 3'd0);
      send();
      @(negedge clk);
      chk("unit_stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      ex = '0;
      ex.valid = 2'b11; ex.pd = p2(13, 12); ex.rdy1 = 2'b11;
      ex.rdy2 = 2'b11; ex.idx = {5'd1, 5'd0}; ex.we = 2'b11;
      ex.rrd = {5'd9, 5'd8}; ex.pop = 2'd2; ex.enq = 2'd2;
      q.push_back(ex);
      unit_space = {NU{2'd2}};
      drain();
      chk("stall_cnt_8", 64'(stall_cnt), 64'd8);

      // flush drops the held group and a same-cycle offer
      rob_space = 5'd0;
      set_slot(0, 1, 5'd10, 5'd0, 5'd0, 1, 3'd0);
      set_slot(1, 1, 5'd11, 5'd0, 5'd0, 1, 3'd0);
      send();
      set_slot(0, 1, 5'd12, 5'd0, 5'd0, 1, 3'd0);
      set_slot(1, 1, 5'd13, 5'd0, 5'd0, 1, 3'd0);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      chk("flush_disp_valid", 64'(disp_valid), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = '0;
      rob_space = 5'd16;
      @(negedge clk);
      chk("post_flush_in_ready", 64'(in_ready), 64'd1);
      chk("post_flush_disp", 64'(disp_valid), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("stall_cnt_flush", 64'(stall_cnt), 64'd8);
      drain();

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
